// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter_pkg
// Purpose  : Shared widths, requester index type and write-request record
//            for the two-port register-file write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_write_arbiter_pkg;

  localparam int DEF_DATA_W = 20;
  localparam int DEF_ADDR_W = 4;

  // Index of a requester port
  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_idx_t;

  // One write request as presented by a requester
  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wr_req_t;

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-way combinational grant with last-grant round-robin pointer.
//            Define RF_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins,
//            no pointer).
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import regfile_write_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     hold,
  input  logic     valid0,
  input  logic     valid1,
  output logic     grant0,
  output logic     grant1,
  output req_idx_t grant_idx
);

`ifndef RF_ARB_FIXED_PRIO_EN
  req_idx_t last_grant;

  // Pointer moves only when a grant (i.e. a transfer) actually happens
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= REQ1;
    end else if (grant0) begin
      last_grant <= REQ0;
    end else if (grant1) begin
      last_grant <= REQ1;
    end
  end
`endif

  // Grant decision; grants imply valid so every grant is a transfer
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && !hold) begin
      if (valid0 && valid1) begin
`ifdef RF_ARB_FIXED_PRIO_EN
        grant0 = 1'b1;
`else
        if (last_grant == REQ1) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
`endif
      end else begin
        grant0 = valid0;
        grant1 = valid1;
      end
    end
  end

  assign grant_idx = grant1 ? REQ1 : REQ0;

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Arbitrates two register-file write requesters onto one write
//            port with a single registered output stage (latency 1).
//            Macro RF_ARB_FIXED_PRIO_EN selects fixed priority arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              wr_enable,
  output logic [ADDR_W-1:0] wr_register,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_src
);

  logic     grant0;
  logic     grant1;
  req_idx_t grant_idx;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (hold),
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .grant0    (grant0),
    .grant1    (grant1),
    .grant_idx (grant_idx)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Output stage: capture only on a grant, otherwise pulse ends and
  // address/data keep their last values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_enable   <= 1'b0;
      wr_register <= '0;
      wr_data     <= '0;
      wr_src      <= 1'b0;
    end else if (grant0 || grant1) begin
      wr_enable   <= 1'b1;
      wr_register <= grant1 ? req1_addr : req0_addr;
      wr_data     <= grant1 ? req1_data : req0_data;
      wr_src      <= grant_idx;
    end else begin
      wr_enable   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Directed, table-driven self-checking bench for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

  localparam int DATA_W = 20;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              hold = 1'b0;
  logic              req0_valid = 1'b0;
  logic [ADDR_W-1:0] req0_addr = '0;
  logic [DATA_W-1:0] req0_data = '0;
  logic              req1_valid = 1'b0;
  logic [ADDR_W-1:0] req1_addr = '0;
  logic [DATA_W-1:0] req1_data = '0;
  logic              req0_ready;
  logic              req1_ready;
  logic              wr_enable;
  logic [ADDR_W-1:0] wr_register;
  logic [DATA_W-1:0] wr_data;
  logic              wr_src;

  int tests = 0;
  int fails = 0;

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold        (hold),
    .req0_valid  (req0_valid),
    .req0_addr   (req0_addr),
    .req0_data   (req0_data),
    .req1_valid  (req1_valid),
    .req1_addr   (req1_addr),
    .req1_data   (req1_data),
    .req0_ready  (req0_ready),
    .req1_ready  (req1_ready),
    .wr_enable   (wr_enable),
    .wr_register (wr_register),
    .wr_data     (wr_data),
    .wr_src      (wr_src)
  );

  always #5 clk = ~clk;

  // Row: inputs for one cycle, expected ready in that cycle, and expected
  // registered outputs seen in that cycle (result of the previous row)
  typedef struct {
    logic        h;
    logic        v0;
    logic [3:0]  a0;
    logic [19:0] d0;
    logic        v1;
    logic [3:0]  a1;
    logic [19:0] d1;
    logic        r0;
    logic        r1;
    logic        we;
    logic [3:0]  reg_e;
    logic [19:0] dat_e;
    logic        src_e;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic h, input logic v0, input logic [3:0] a0, input logic [19:0] d0,
                     input logic v1, input logic [3:0] a1, input logic [19:0] d1,
                     input logic r0, input logic r1, input logic we,
                     input logic [3:0] rg, input logic [19:0] dt, input logic src);
    vec_t v;
    v.h = h; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.we = we; v.reg_e = rg; v.dat_e = dt; v.src_e = src;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic h, input logic v0, input logic [3:0] a0, input logic [19:0] d0,
                       input logic v1, input logic [3:0] a1, input logic [19:0] d1);
    hold = h; req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  task automatic check_outs(input string tag, input logic we, input logic [3:0] rg,
                            input logic [19:0] dt, input logic src);
    check({tag, ".wr_enable"},   32'(wr_enable),   32'(we));
    check({tag, ".wr_register"}, 32'(wr_register), 32'(rg));
    check({tag, ".wr_data"},     32'(wr_data),     32'(dt));
    check({tag, ".wr_src"},      32'(wr_src),      32'(src));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      drive(vecs[i].h, vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
      @(negedge clk);
      check($sformatf("%s[%0d].req0_ready", tag, i), 32'(req0_ready), 32'(vecs[i].r0));
      check($sformatf("%s[%0d].req1_ready", tag, i), 32'(req1_ready), 32'(vecs[i].r1));
      check_outs($sformatf("%s[%0d]", tag, i), vecs[i].we, vecs[i].reg_e, vecs[i].dat_e, vecs[i].src_e);
    end
  endtask

  initial begin
    // Reset state, with a requester valid: ready must stay low
    rst_n = 1'b0;
    drive(0, 1, 4'd3, 20'h12345, 1, 4'd4, 20'h00004);
    #12;
    check("reset.req0_ready", 32'(req0_ready), 32'd0);
    check("reset.req1_ready", 32'(req1_ready), 32'd0);
    check_outs("reset", 0, 0, 0, 0);

    // Single request straight after reset release
    do_reset();
    @(posedge clk); #1;
    drive(0, 1, 4'd3, 20'h12345, 0, 0, 0);
    @(negedge clk);
    check("single.req0_ready", 32'(req0_ready), 32'd1);
    check("single.req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_outs("single", 1, 4'd3, 20'h12345, 0);

`ifndef RF_ARB_FIXED_PRIO_EN
    // Round-robin table, starting from reset (pointer favours requester 0)
    //  h  v0 a0 d0            v1 a1 d1            r0 r1 we reg dat         src
    add(0, 1, 1, 20'h00010,    1, 2, 20'h00020,    1, 0, 0, 0, 20'h00000,   0);
    add(0, 1, 1, 20'h00011,    1, 2, 20'h00020,    0, 1, 1, 1, 20'h00010,   0);
    add(0, 1, 1, 20'h00011,    1, 2, 20'h00021,    1, 0, 1, 2, 20'h00020,   1);
    add(0, 1, 1, 20'h00012,    1, 2, 20'h00021,    0, 1, 1, 1, 20'h00011,   0);
    add(0, 0, 0, 20'h00000,    0, 0, 20'h00000,    0, 0, 1, 2, 20'h00021,   1);
    add(0, 0, 0, 20'h00000,    0, 0, 20'h00000,    0, 0, 0, 2, 20'h00021,   1);
    // hold for 3 cycles, then contention on one address
    add(1, 1, 5, 20'hAAAAA,    1, 5, 20'h55555,    0, 0, 0, 2, 20'h00021,   1);
    add(1, 1, 5, 20'hAAAAA,    1, 5, 20'h55555,    0, 0, 0, 2, 20'h00021,   1);
    add(1, 1, 5, 20'hAAAAA,    1, 5, 20'h55555,    0, 0, 0, 2, 20'h00021,   1);
    add(0, 1, 5, 20'hAAAAA,    1, 5, 20'h55555,    1, 0, 0, 2, 20'h00021,   1);
    add(0, 0, 0, 20'h00000,    1, 5, 20'h55555,    0, 1, 1, 5, 20'hAAAAA,   0);
    add(0, 0, 0, 20'h00000,    0, 0, 20'h00000,    0, 0, 1, 5, 20'h55555,   1);
    // lone requester 1 does not move pointer preference out of order
    add(0, 0, 0, 20'h00000,    1, 7, 20'h0ABCD,    0, 1, 0, 5, 20'h55555,   1);
    add(0, 1, 8, 20'h00001,    1, 9, 20'h00002,    1, 0, 1, 7, 20'h0ABCD,   1);
    add(0, 0, 0, 20'h00000,    1, 9, 20'h00002,    0, 1, 1, 8, 20'h00001,   0);
    add(0, 0, 0, 20'h00000,    0, 0, 20'h00000,    0, 0, 1, 9, 20'h00002,   1);
    // hold raised right after an acceptance: the write still issues
    add(0, 1, 4, 20'h00444,    0, 0, 20'h00000,    1, 0, 0, 9, 20'h00002,   1);
    add(1, 1, 4, 20'h00445,    1, 6, 20'h00666,    0, 0, 1, 4, 20'h00444,   0);
    add(0, 1, 4, 20'h00445,    1, 6, 20'h00666,    0, 1, 0, 4, 20'h00444,   0);
    add(0, 0, 0, 20'h00000,    0, 0, 20'h00000,    0, 0, 1, 6, 20'h00666,   1);
    do_reset();
    run_table("rr");
`else
    // Fixed priority: requester 0 wins every contended cycle
    add(0, 1, 1, 20'h00010,    1, 2, 20'h00020,    1, 0, 0, 0, 20'h00000,   0);
    add(0, 1, 1, 20'h00011,    1, 2, 20'h00020,    1, 0, 1, 1, 20'h00010,   0);
    add(0, 1, 1, 20'h00012,    1, 2, 20'h00020,    1, 0, 1, 1, 20'h00011,   0);
    add(0, 0, 0, 20'h00000,    0, 0, 20'h00000,    0, 0, 1, 1, 20'h00012,   0);
    do_reset();
    run_table("fp");
`endif

    // Reset asserted while a request is being accepted: no write pulse
    do_reset();
    @(posedge clk); #1;
    drive(0, 1, 4'd3, 20'h00333, 0, 0, 0);
    @(negedge clk);
    check("rstacc.req0_ready", 32'(req0_ready), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstacc.ready_in_reset", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    check_outs("rstacc", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check_outs("rstacc.after", 0, 0, 0, 0);

    // Reset asserted while a write pulse is active: drops immediately
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 4'd9, 20'h00999);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_outs("rstpulse.before", 1, 4'd9, 20'h00999, 1);
    #2 rst_n = 1'b0;
    #1;
    check_outs("rstpulse.async", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 20, register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 4, register address width (16 registers).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; ports are named clk and rst_n.
REQ-004 Ports SHALL be: clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 hold  in  1  blocks new grants while high.
REQ-007 req0_valid / req1_valid  in  1  requester N has a write pending.
REQ-008 req0_addr / req1_addr  in  ADDR_W  target register.
REQ-009 req0_data / req1_data  in  DATA_W  write value.
REQ-010 req0_ready / req1_ready  out  1  requester N accepted this cycle.
REQ-011 wr_enable  out  1  register-file write enable.
REQ-012 wr_register  out  ADDR_W  register-file write address.
REQ-013 wr_data  out  DATA_W  register-file write data.
REQ-014 wr_src  out  1  requester index of the current wr_* transfer.

Function
REQ-015 A transfer SHALL occur on a rising clk edge where reqN_valid and reqN_ready are both high.
REQ-016 reqN_ready SHALL be combinational, at most one ready high per cycle, and both low while hold=1.
REQ-017 With one requester valid and hold=0, that requester SHALL be granted the same cycle.
REQ-018 With both valid and hold=0, the requester not granted most recently SHALL be granted (round-robin).
REQ-019 The last-grant pointer SHALL update only on a completed transfer; idle and hold cycles SHALL leave it unchanged.
REQ-020 wr_enable, wr_register, wr_data and wr_src SHALL be registered, presenting an accepted transfer exactly one cycle after acceptance (latency 1).
REQ-021 wr_enable SHALL be high for exactly one cycle per transfer, so back-to-back transfers give one write per cycle.
REQ-022 wr_register/wr_data SHALL hold their last values when wr_enable=0.
REQ-023 Both requesters targeting the same address SHALL be serialised by REQ-018; the later write wins in the register file, with no merging.
REQ-024 A requester SHALL keep valid, addr and data stable until ready; the arbiter SHALL NOT capture values from a cycle without ready.
REQ-025 Raising hold SHALL NOT cancel a transfer accepted in the previous cycle; its wr_enable pulse SHALL still issue.

Reset
REQ-026 While rst_n=0, wr_enable, wr_register, wr_data and wr_src SHALL be 0 and the last-grant pointer SHALL be 1, so requester 0 wins the first contention.
REQ-027 Asserting rst_n mid-operation SHALL immediately drop wr_enable and discard any accepted-but-unwritten transfer.
REQ-028 reqN_ready SHALL be 0 while rst_n=0.

Configuration
REQ-029 Macro RF_ARB_FIXED_PRIO_EN, when defined, SHALL replace round-robin with fixed priority: requester 0 always wins contention and the last-grant pointer is not implemented.
REQ-030 Without RF_ARB_FIXED_PRIO_EN, REQ-018/REQ-019 round-robin behaviour SHALL apply.

Structure
REQ-031 A shared package SHALL hold DATA_W/ADDR_W defaults, the requester-index type and a write-request struct (valid, addr, data).
REQ-032 A sub-module rr_arbiter2 SHALL implement the two-way grant logic and pointer.
REQ-033 The top SHALL hold the output register stage.

Verification
REQ-034 Reset release, req0 addr 3 data 0x12345 -> req0_ready same cycle; next cycle wr_enable=1, wr_register=3, wr_data=0x12345, wr_src=0.
REQ-035 Both valid for 4 cycles from reset (addr 1 / addr 2) -> grants 0,1,0,1; wr_src sequence 0,1,0,1 with no gaps.
REQ-036 Both valid on addr 5, req0 data 0xAAAAA, req1 data 0x55555 -> two writes in grant order; last wr_data is req1's value.
REQ-037 hold=1 for 3 cycles with both valid -> no ready, no wr_enable; pointer unchanged, so the next grant follows round-robin.
REQ-038 rst_n low in the cycle after acceptance -> no wr_enable pulse; outputs return to 0.
REQ-039 RF_ARB_FIXED_PRIO_EN defined, both valid for 3 cycles -> req0 granted every cycle, req1 never ready.
